// File: rtl/vx_ibuffer_mq.sv
// ---------------------------------------------------------------------------
// vx_ibuffer_mq
//
// Multi-queue instruction buffer between decode and issue. Each warp owns an
// independent circular FIFO of DEPTH decoded instructions. One instruction
// per cycle is offered to issue, chosen round-robin among non-empty warps,
// and a one-cycle lookahead of the following warp is exposed so the
// scoreboard lookup can start early. Per-warp flush and full/empty status.
//
// Optional feature macro: VX_IBUFFER_BYPASS_EN
//   When defined, an instruction arriving while every queue is empty is
//   offered on deq_* in the same cycle and is not stored if accepted.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   enq_valid/wid/data  decoded instruction in; enq_ready is the handshake
//   warp_full/empty     per-warp status vectors
//   flush_valid/wid     discard the whole queue of one warp
//   deq_valid/wid/data  instruction offered to issue; deq_ready accepts
//   next_valid/wid      warp offered next cycle if this cycle's offer fires
// ---------------------------------------------------------------------------
module vx_ibuffer_mq #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 4,
    parameter int DATAW     = 128,
    localparam int NW       = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq_valid,
    input  logic [NW-1:0]        enq_wid,
    input  logic [DATAW-1:0]     enq_data,
    output logic                 enq_ready,
    output logic [NUM_WARPS-1:0] warp_full,
    output logic [NUM_WARPS-1:0] warp_empty,
    input  logic                 flush_valid,
    input  logic [NW-1:0]        flush_wid,
    output logic                 deq_valid,
    output logic [NW-1:0]        deq_wid,
    output logic [DATAW-1:0]     deq_data,
    input  logic                 deq_ready,
    output logic                 next_valid,
    output logic [NW-1:0]        next_wid
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          w_cnt    [NUM_WARPS];
    logic [AW-1:0]        w_rd_ptr [NUM_WARPS];
    logic [AW-1:0]        w_wr_ptr [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_push;
    logic [NUM_WARPS-1:0] w_pop;
    logic [NUM_WARPS-1:0] w_flush;
    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_la_elig;
    logic [NW-1:0]        w_sel;
    logic [NW-1:0]        w_next_sel;
    logic                 w_enq_fire;
    logic                 w_bypass;
    logic                 w_write;
    logic                 w_fire;
    logic [NW-1:0]        r_rr_ptr;

    // Payload storage, addressed as {warp, slot}. Read is asynchronous
    // because the head must be visible in the same cycle it is selected.
    logic [DATAW-1:0]     r_mem [NUM_WARPS*DEPTH];

    // ------------------------------------------------------------------
    // Per-warp queue state
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [AW:0]   r_cnt;
            logic [AW-1:0] r_rd_ptr;
            logic [AW-1:0] r_wr_ptr;

            assign w_flush[gi]    = flush_valid && (flush_wid == NW'(gi));
            assign w_push[gi]     = w_write && (enq_wid == NW'(gi));
            assign w_pop[gi]      = w_fire && !w_bypass && (w_sel == NW'(gi));
            assign w_elig[gi]     = (r_cnt != '0) && !w_flush[gi];
            assign warp_full[gi]  = (r_cnt == (AW+1)'(DEPTH));
            assign warp_empty[gi] = (r_cnt == '0);
            assign w_cnt[gi]      = r_cnt;
            assign w_rd_ptr[gi]   = r_rd_ptr;
            assign w_wr_ptr[gi]   = r_wr_ptr;

            // A flushed warp can neither push nor pop this cycle, so the
            // flush simply clears the queue.
            always_ff @(posedge clk) begin
                if (reset || w_flush[gi]) begin
                    r_cnt    <= '0;
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                end else begin
                    if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Enqueue handshake and optional same-cycle bypass
    // ------------------------------------------------------------------
    assign enq_ready  = !warp_full[enq_wid] && !(flush_valid && (flush_wid == enq_wid));
    assign w_enq_fire = enq_valid && enq_ready;

`ifdef VX_IBUFFER_BYPASS_EN
    // enq_ready already excludes a warp being flushed.
    assign w_bypass = w_enq_fire && (&warp_empty);
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction accepted by issue never touches storage.
    assign w_write = w_enq_fire && !(w_bypass && deq_ready);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[{enq_wid, w_wr_ptr[enq_wid]}] <= enq_data;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin selection: scan from the highest offset down so the
    // smallest offset from r_rr_ptr wins.
    // ------------------------------------------------------------------
    always_comb begin
        logic [NW-1:0] v_idx;
        v_idx = '0;
        w_sel = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            v_idx = r_rr_ptr + NW'(i);
            if (w_elig[v_idx]) w_sel = v_idx;
        end
    end

    // Lookahead assumes the current offer fires: the selected warp drops
    // out if it holds its last entry. Scan offsets 1..NUM_WARPS so the
    // selected warp itself is considered last.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_la_elig[w] = w_elig[w] && !((w_sel == NW'(w)) && (w_cnt[w] == (AW+1)'(1)));
        end
    end

    always_comb begin
        logic [NW-1:0] v_idx;
        v_idx      = '0;
        w_next_sel = '0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            v_idx = w_sel + NW'(i);
            if (w_la_elig[v_idx]) w_next_sel = v_idx;
        end
    end

    assign next_valid = |w_la_elig;
    assign next_wid   = w_next_sel;

    // ------------------------------------------------------------------
    // Dequeue outputs
    // ------------------------------------------------------------------
`ifdef VX_IBUFFER_BYPASS_EN
    assign deq_valid = (|w_elig) || w_bypass;
    assign deq_wid   = w_bypass ? enq_wid  : w_sel;
    assign deq_data  = w_bypass ? enq_data : r_mem[{w_sel, w_rd_ptr[w_sel]}];
`else
    assign deq_valid = |w_elig;
    assign deq_wid   = w_sel;
    assign deq_data  = r_mem[{w_sel, w_rd_ptr[w_sel]}];
`endif

    assign w_fire = deq_valid && deq_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_fire) begin
            r_rr_ptr <= deq_wid + NW'(1);
        end
    end

endmodule

// File: tb/tb_vx_ibuffer_mq.sv
module tb_vx_ibuffer_mq;

    logic         clk;
    logic         reset;
    logic         enq_valid;
    logic [1:0]   enq_wid;
    logic [127:0] enq_data;
    logic         enq_ready;
    logic [3:0]   warp_full;
    logic [3:0]   warp_empty;
    logic         flush_valid;
    logic [1:0]   flush_wid;
    logic         deq_valid;
    logic [1:0]   deq_wid;
    logic [127:0] deq_data;
    logic         deq_ready;
    logic         next_valid;
    logic [1:0]   next_wid;

    vx_ibuffer_mq #(.NUM_WARPS(4), .DEPTH(4), .DATAW(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .enq_valid  (enq_valid),
        .enq_wid    (enq_wid),
        .enq_data   (enq_data),
        .enq_ready  (enq_ready),
        .warp_full  (warp_full),
        .warp_empty (warp_empty),
        .flush_valid(flush_valid),
        .flush_wid  (flush_wid),
        .deq_valid  (deq_valid),
        .deq_wid    (deq_wid),
        .deq_data   (deq_data),
        .deq_ready  (deq_ready),
        .next_valid (next_valid),
        .next_wid   (next_wid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   wid;
        logic [127:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid   = 1'b0;
        flush_valid = 1'b0;
        deq_ready   = 1'b0;
    endtask

    task automatic enq(input logic [1:0] wid, input logic [127:0] data);
        enq_valid = 1'b1;
        enq_wid   = wid;
        enq_data  = data;
    endtask

    task automatic expect_deq(input logic [1:0] wid, input logic [127:0] data);
        sb_q.push_back('{wid: wid, data: data});
    endtask

    // Scoreboard monitor: every accepted offer is compared with the oldest
    // expected entry.
    always @(negedge clk) begin
        if (!reset && deq_valid && deq_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_deq: got wid %0d data %0h, expected none", deq_wid, deq_data);
            end else begin
                mon_e = sb_q.pop_front();
                $display("deq wid=%0d data=%0h (expected wid=%0d data=%0h)", deq_wid, deq_data, mon_e.wid, mon_e.data);
                chk("deq_wid", 128'(deq_wid), 128'(mon_e.wid));
                chk("deq_data", deq_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        idle();
        enq_wid = '0;
        enq_data = '0;
        flush_wid = '0;
        repeat (3) cyc();

        // Reset state
        @(negedge clk);
        chk("rst_deq_valid", 128'(deq_valid), 0);
        chk("rst_next_valid", 128'(next_valid), 0);
        chk("rst_warp_empty", 128'(warp_empty), 128'hF);
        chk("rst_warp_full", 128'(warp_full), 0);
        chk("rst_enq_ready", 128'(enq_ready), 1);
        chk("rst_deq_wid", 128'(deq_wid), 0);
        chk("rst_next_wid", 128'(next_wid), 0);
        cyc();
        reset = 1'b0;

        // Single enqueue to warp 2, offered one cycle later
        enq(2'd2, 128'hA5);
        @(negedge clk);
        chk("t1_enq_ready", 128'(enq_ready), 1);
`ifndef VX_IBUFFER_BYPASS_EN
        chk("t1_no_same_cycle", 128'(deq_valid), 0);
`endif
        cyc();
        idle();
        @(negedge clk);
        chk("t1_deq_valid", 128'(deq_valid), 1);
        chk("t1_deq_wid", 128'(deq_wid), 2);
        chk("t1_deq_data", deq_data, 128'hA5);
        chk("t1_warp_empty", 128'(warp_empty), 128'b1011);
        chk("t1_next_valid", 128'(next_valid), 0);
        cyc();
        expect_deq(2'd2, 128'hA5);
        deq_ready = 1'b1;
        cyc();
        idle();
        @(negedge clk);
        chk("t1_empty_after", 128'(warp_empty), 128'hF);
        chk("t1_deq_valid_after", 128'(deq_valid), 0);
        cyc();

        // Fill warp 1, refuse a fifth entry, drain in order
        for (int i = 0; i < 4; i++) begin
            enq(2'd1, 128'(8'h11 + i));
            @(negedge clk);
            chk("t2_enq_ready", 128'(enq_ready), 1);
            cyc();
        end
        enq_valid = 1'b0;
        enq_wid = 2'd0;
        @(negedge clk);
        chk("t2_warp_full", 128'(warp_full), 128'b0010);
        chk("t2_enq_ready_w0", 128'(enq_ready), 1);
        chk("t2_warp_empty", 128'(warp_empty), 128'b1101);
        cyc();
        enq(2'd1, 128'h15);
        @(negedge clk);
        chk("t2_enq_ready_w1", 128'(enq_ready), 0);
        cyc();
        idle();
        for (int i = 0; i < 4; i++) expect_deq(2'd1, 128'(8'h11 + i));
        deq_ready = 1'b1;
        @(negedge clk);
        chk("t2_next_valid", 128'(next_valid), 1);
        chk("t2_next_wid", 128'(next_wid), 1);
        repeat (4) cyc();
        idle();
        @(negedge clk);
        chk("t2_fifth_not_stored", 128'(warp_empty), 128'hF);
        chk("t2_deq_valid_after", 128'(deq_valid), 0);
        cyc();

        // Round robin from rr_ptr=0 over warps 0,1,3 with lookahead
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        enq(2'd0, 128'h30); cyc();
        enq(2'd1, 128'h31); cyc();
        enq(2'd3, 128'h33); cyc();
        idle();
        expect_deq(2'd0, 128'h30);
        expect_deq(2'd1, 128'h31);
        expect_deq(2'd3, 128'h33);
        deq_ready = 1'b1;
        @(negedge clk);
        chk("t3_next_valid0", 128'(next_valid), 1);
        chk("t3_next_wid0", 128'(next_wid), 1);
        cyc();
        @(negedge clk);
        chk("t3_next_valid1", 128'(next_valid), 1);
        chk("t3_next_wid1", 128'(next_wid), 3);
        cyc();
        @(negedge clk);
        chk("t3_next_valid2", 128'(next_valid), 0);
        cyc();
        idle();

        // Flush warp 0 (3 entries) while enqueueing to it; warp 2 holds one
        enq(2'd2, 128'h52); cyc();
        enq(2'd0, 128'h40); cyc();
        enq(2'd0, 128'h41); cyc();
        enq(2'd0, 128'h42); cyc();
        idle();
        flush_valid = 1'b1;
        flush_wid = 2'd0;
        enq(2'd0, 128'h43);
        @(negedge clk);
        chk("t4_enq_ready", 128'(enq_ready), 0);
        chk("t4_deq_valid", 128'(deq_valid), 1);
        chk("t4_deq_wid", 128'(deq_wid), 2);
        chk("t4_next_valid", 128'(next_valid), 0);
        cyc();
        idle();
        @(negedge clk);
        chk("t4_warp_empty", 128'(warp_empty), 128'b1011);
        cyc();
        expect_deq(2'd2, 128'h52);
        deq_ready = 1'b1;
        cyc();
        idle();
        @(negedge clk);
        chk("t4_empty_after", 128'(warp_empty), 128'hF);
        cyc();

        // Full warp 2: pop and enqueue together, enqueue refused
        for (int i = 0; i < 4; i++) begin
            enq(2'd2, 128'(8'h60 + i));
            cyc();
        end
        idle();
        @(negedge clk);
        chk("t5_warp_full", 128'(warp_full), 128'b0100);
        cyc();
        enq(2'd2, 128'h64);
        deq_ready = 1'b1;
        expect_deq(2'd2, 128'h60);
        @(negedge clk);
        chk("t5_enq_ready", 128'(enq_ready), 0);
        chk("t5_deq_wid", 128'(deq_wid), 2);
        cyc();
        idle();
        @(negedge clk);
        chk("t5_warp_full_after", 128'(warp_full), 0);
        chk("t5_warp_empty", 128'(warp_empty), 128'b1011);
        cyc();
        for (int i = 1; i < 4; i++) expect_deq(2'd2, 128'(8'h60 + i));
        deq_ready = 1'b1;
        repeat (3) cyc();
        idle();
        @(negedge clk);
        chk("t5_cnt_was_3", 128'(warp_empty), 128'hF);
        cyc();

        // Same-warp enqueue and pop in one cycle (non-full queue)
        enq(2'd3, 128'h70);
        cyc();
        enq(2'd3, 128'h71);
        deq_ready = 1'b1;
        expect_deq(2'd3, 128'h70);
        @(negedge clk);
        chk("t5b_enq_ready", 128'(enq_ready), 1);
        cyc();
        idle();
        @(negedge clk);
        chk("t5b_warp_empty", 128'(warp_empty), 128'b0111);
        cyc();
        expect_deq(2'd3, 128'h71);
        deq_ready = 1'b1;
        cyc();
        idle();
        @(negedge clk);
        chk("t5b_empty_after", 128'(warp_empty), 128'hF);
        cyc();

        // Enqueue into an all-empty buffer with issue ready
        enq(2'd3, 128'h5A);
`ifdef VX_IBUFFER_BYPASS_EN
        deq_ready = 1'b1;
        expect_deq(2'd3, 128'h5A);
        @(negedge clk);
        chk("t6_deq_valid", 128'(deq_valid), 1);
        chk("t6_deq_wid", 128'(deq_wid), 3);
        chk("t6_deq_data", deq_data, 128'h5A);
        cyc();
        idle();
        @(negedge clk);
        chk("t6_warp_empty", 128'(warp_empty), 128'hF);
        chk("t6_deq_valid_after", 128'(deq_valid), 0);
`else
        deq_ready = 1'b1;
        @(negedge clk);
        chk("t6_no_bypass", 128'(deq_valid), 0);
        cyc();
        idle();
        @(negedge clk);
        chk("t6_deq_valid", 128'(deq_valid), 1);
        chk("t6_deq_wid", 128'(deq_wid), 3);
        cyc();
        expect_deq(2'd3, 128'h5A);
        deq_ready = 1'b1;
        cyc();
        idle();
        @(negedge clk);
        chk("t6_warp_empty", 128'(warp_empty), 128'hF);
`endif
        cyc();
        cyc();
        chk("scoreboard_drained", 128'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_ibuffer_mq.md
# vx_ibuffer_mq

Parametrised multi-queue instruction buffer between decode and issue. Holds up to DEPTH decoded instructions per warp in independent FIFOs, presents one instruction per cycle to issue through round-robin arbitration across non-empty warps, and exposes a one-cycle lookahead of the next warp to be issued for early scoreboard lookup. Adds per-warp flush and per-warp full/empty status.

## Interface
Parameters:
- NUM_WARPS, 4, number of warp queues; power of 2, at least 2; NW = log2(NUM_WARPS)
- DEPTH, 4, entries per warp queue; power of 2, at least 2
- DATAW, 128, packed decoded-instruction payload width (uuid, tmask, PC, ex/op fields, rd/rs1-3, imm, flags)

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- enq_valid  in  1  decoded instruction valid
- enq_wid  in  NW  destination warp
- enq_data  in  DATAW  payload
- enq_ready  out  1  = !warp_full[enq_wid] && !(flush_valid && flush_wid == enq_wid)
- warp_full  out  NUM_WARPS  per-warp queue holds DEPTH entries
- warp_empty  out  NUM_WARPS  per-warp queue holds 0 entries
- flush_valid  in  1  discard the entire queue of flush_wid
- flush_wid  in  NW  warp to flush
- deq_valid  out  1  an instruction is offered to issue
- deq_wid  out  NW  warp of offered instruction
- deq_data  out  DATAW  head payload of deq_wid
- deq_ready  in  1  issue accepts; fire = deq_valid && deq_ready
- next_valid  out  1  lookahead valid
- next_wid  out  NW  warp that deq will offer next cycle if fire occurs this cycle

## Operation
- Storage: per-warp circular FIFO, DEPTH x DATAW; rd_ptr/wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH; cnt is log2(DEPTH)+1 bits.
- Enqueue: on enq_valid && enq_ready, write enq_data at wr_ptr[enq_wid], increment wr_ptr and cnt.
- Eligible set: warps with cnt != 0, excluding flush_wid when flush_valid.
- Arbitration: rr_ptr register (NW bits). sel = first eligible warp scanning rr_ptr, rr_ptr+1, ... modulo NUM_WARPS. deq_valid = eligible set non-empty; deq_wid = sel; deq_data = head of sel.
- On fire: increment rd_ptr[sel], decrement cnt[sel]; rr_ptr <= sel + 1 (modulo NUM_WARPS). No fire: rr_ptr holds.
- Lookahead: next_wid = first warp scanning from sel+1 whose count after this cycle's pop (and excluding any flushed warp) is non-zero; includes sel itself last if it still holds entries. next_valid = such a warp exists. Enqueues arriving this cycle are not counted in the lookahead.
- Flush: cnt, rd_ptr, wr_ptr of flush_wid reset to 0 next cycle; enqueue to that warp is refused in the flush cycle; flushed warp is never selected in the flush cycle.
- Same-warp enqueue and pop in one cycle: cnt unchanged, both pointers advance. A full queue refuses enqueue even when it is popped in the same cycle.
- Reset: all cnt/pointers 0, rr_ptr 0; outputs deq_valid 0, next_valid 0, warp_empty all 1, warp_full all 0, enq_ready 1. deq_wid/next_wid 0, deq_data don't-care. Reset mid-operation discards all entries.

## Timing
- Enqueue-to-offer latency: 1 cycle (written at edge t, offered from cycle t+1), except under bypass (Configuration).
- deq_valid/deq_wid/deq_data and next_* are combinational from registered state (plus flush inputs); no dependence on deq_ready.
- deq_valid, once asserted, is not required to hold its warp across cycles; a flush may withdraw it.
- enq_ready combinational from warp_full, enq_wid, flush inputs.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Configuration
- VX_IBUFFER_BYPASS_EN defined: when every queue is empty (before this cycle's enqueue), enq_valid && enq_ready and the warp is not being flushed, the incoming instruction is offered same cycle (deq_valid=1, deq_wid=enq_wid, deq_data=enq_data); if deq_ready, it is not written and cnt stays 0; otherwise it is written normally. rr_ptr update as for a normal fire.
- Undefined: no combinational enq-to-deq path; minimum latency 1 cycle.

## Test plan
- Reset, then enqueue warp 2 data 0xA5 with deq_ready=0 -> cycle after: deq_valid=1, deq_wid=2, deq_data=0xA5, warp_empty=4'b1011.
- Fill warp 1 with 4 entries (DEPTH=4), deq_ready=0 -> warp_full[1]=1, enq_ready=0 for wid 1, 1 for wid 0; fifth enqueue not stored; drain returns entries in order.
- One entry each in warps 0,1,3, rr_ptr=0, deq_ready=1 -> deq_wid sequence 0,1,3; next_wid 1,3 then next_valid=0.
- Warp 0 holds 3 entries, flush_valid=1 flush_wid=0 with enq_valid to wid 0 -> enq_ready=0, warp 0 not selected, next cycle warp_empty[0]=1.
- Warp 2 full, simultaneous pop of warp 2 and enqueue to warp 2 -> enqueue refused, cnt becomes 3.
- With VX_IBUFFER_BYPASS_EN, all empty, enqueue wid 3 data 0x5A, deq_ready=1 -> same cycle deq_valid=1, deq_wid=3, deq_data=0x5A; next cycle warp_empty all 1.
